// File: rtl/lfsr_step_if.sv
// Request/strobe bundle between the button conditioning logic and the LFSR
// step controller. The master issues requests and observes the strobes and
// status; the slave (the controller) consumes requests and drives strobes.
interface lfsr_step_if;
  logic [1:0]  div_sel;
  logic        run_req;
  logic        stop_req;
  logic        step_req;
  logic        load_req;
  logic        lfsr_en;
  logic        lfsr_load;
  logic [1:0]  state;
  logic [15:0] step_cnt;

  modport master (
    output div_sel, run_req, stop_req, step_req, load_req,
    input  lfsr_en, lfsr_load, state, step_cnt
  );

  modport slave (
    input  div_sel, run_req, stop_req, step_req, load_req,
    output lfsr_en, lfsr_load, state, step_cnt
  );
endinterface

// File: rtl/lfsr_step_ctrl.sv
// LFSR step controller: rate divider plus a small FSM that turns single-cycle
// button requests into single-cycle LFSR advance/load strobes.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   S_IDLE | waiting for a request, divider held at 0
//   S_RUN  | free-run, one lfsr_en every PER[div_sel] cycles
//   S_STEP | single advance, lfsr_en high for this one cycle
//   S_LOAD | seed load, lfsr_load high for this one cycle, step_cnt = 0
//
// All outputs are registered, so a request seen in cycle n acts in cycle n+1.
// A load request wins over everything else in every state.
module lfsr_step_ctrl #(
  parameter int CNT_W = 26,
  parameter int PER0  = 50_000_000,
  parameter int PER1  = 25_000_000,
  parameter int PER2  = 5_000_000,
  parameter int PER3  = 500_000
) (
  input  logic        clk,
  input  logic        rst,
  lfsr_step_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_LOAD = 2'd3
  } state_t;

  // Terminal counts are PER-1: the divider counts 0..PER-1, then strobes.
  localparam logic [CNT_W-1:0] LP_TC0 = CNT_W'(PER0 - 1);
  localparam logic [CNT_W-1:0] LP_TC1 = CNT_W'(PER1 - 1);
  localparam logic [CNT_W-1:0] LP_TC2 = CNT_W'(PER2 - 1);
  localparam logic [CNT_W-1:0] LP_TC3 = CNT_W'(PER3 - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]  w_tc;
  logic              r_en;
  logic              w_en_nxt;
  logic              r_load;
  logic              w_load_nxt;
  logic [15:0]       r_step_cnt;
  logic [15:0]       w_step_cnt_nxt;

  // Select the terminal count live from div_sel so a mid-run change applies at once.
  always_comb begin
    case (bus.div_sel)
      2'd0:    w_tc = LP_TC0;
      2'd1:    w_tc = LP_TC1;
      2'd2:    w_tc = LP_TC2;
      default: w_tc = LP_TC3;
    endcase
  end

  // Next state, next divider value and next strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_en_nxt    = 1'b0;
    w_load_nxt  = 1'b0;
    if (bus.load_req) begin
      w_state_nxt = S_LOAD;
      w_load_nxt  = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.step_req) begin
            w_state_nxt = S_STEP;
            w_en_nxt    = 1'b1;
          end else if (bus.run_req) begin
            w_state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (bus.stop_req) begin
            w_state_nxt = S_IDLE;
          end else if (r_cnt >= w_tc) begin
            // '>=' so a counter already past a newly shortened period wraps now.
            w_en_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_STEP:  w_state_nxt = S_IDLE;
        S_LOAD:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Strobe count tracks the registered strobe; a load clears it in the LOAD cycle.
  always_comb begin
    w_step_cnt_nxt = r_step_cnt;
    if (w_load_nxt) begin
      w_step_cnt_nxt = '0;
    end else if (w_en_nxt) begin
      w_step_cnt_nxt = r_step_cnt + 16'd1;
    end
  end

  // State, divider and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_en       <= 1'b0;
      r_load     <= 1'b0;
      r_step_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_en       <= w_en_nxt;
      r_load     <= w_load_nxt;
      r_step_cnt <= w_step_cnt_nxt;
    end
  end

  assign bus.lfsr_en   = r_en;
  assign bus.lfsr_load = r_load;
  assign bus.state     = r_state;
  assign bus.step_cnt  = r_step_cnt;

endmodule

// File: tb/tb_lfsr_step_ctrl.sv
// Bench for lfsr_step_ctrl with short periods (5/3/2/1). Directed stimulus
// pushes the hand-computed strobe cycle, kind, state and step count of every
// expected strobe into a queue; a negedge monitor pops and compares whenever
// the controller raises a strobe, or when an expected strobe is overdue.
module tb_lfsr_step_ctrl;

  typedef struct {
    int          cyc;
    logic        en;
    logic        load;
    logic [1:0]  st;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_cnt = 16'd0;
  exp_t        exp_q[$];
  exp_t        e;
  int          c;

  lfsr_step_if u_if ();

  lfsr_step_ctrl #(
    .CNT_W (26),
    .PER0  (5),
    .PER1  (3),
    .PER2  (2),
    .PER3  (1)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  always #5 clk = ~clk;

  // Bench cycle number: value seen during the period following each rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go_to(input int t);
    while (cyc < t) tick(1);
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_en(input int at, input logic [1:0] st);
    exp_cnt = exp_cnt + 16'd1;
    exp_q.push_back('{cyc: at, en: 1'b1, load: 1'b0, st: st, cnt: exp_cnt});
  endtask

  task automatic push_load(input int at);
    exp_cnt = 16'd0;
    exp_q.push_back('{cyc: at, en: 1'b0, load: 1'b1, st: 2'd3, cnt: 16'd0});
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (u_if.lfsr_en === 1'b1 || u_if.lfsr_load === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_strobe: cycle %0d en=%0b load=%0b state=%0d, expected no strobe",
                 cyc, u_if.lfsr_en, u_if.lfsr_load, u_if.state);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.en !== u_if.lfsr_en || e.load !== u_if.lfsr_load ||
            e.st !== u_if.state || e.cnt !== u_if.step_cnt) begin
          fails++;
          $display("FAIL strobe: got cycle %0d en=%0b load=%0b state=%0d cnt=%0d, expected cycle %0d en=%0b load=%0b state=%0d cnt=%0d",
                   cyc, u_if.lfsr_en, u_if.lfsr_load, u_if.state, u_if.step_cnt,
                   e.cyc, e.en, e.load, e.st, e.cnt);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      tests++;
      fails++;
      e = exp_q.pop_front();
      $display("FAIL missing_strobe: got no strobe at cycle %0d, expected en=%0b load=%0b cnt=%0d at cycle %0d",
               cyc, e.en, e.load, e.cnt, e.cyc);
    end
  end

  // Watchdog.
  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    u_if.div_sel  = 2'd0;
    u_if.run_req  = 1'b0;
    u_if.stop_req = 1'b0;
    u_if.step_req = 1'b0;
    u_if.load_req = 1'b0;

    // Reset state.
    rst = 1'b1;
    tick(3);
    check("reset_state", u_if.state, 0);
    check("reset_en", u_if.lfsr_en, 0);
    check("reset_load", u_if.lfsr_load, 0);
    check("reset_step_cnt", u_if.step_cnt, 0);
    rst = 1'b0;
    tick(2);

    // Free-run at PER0=5: strobes at n+6, n+11, n+16; stop at n+17.
    u_if.div_sel = 2'd0;
    c = cyc;
    push_en(c + 6, 2'd1);
    push_en(c + 11, 2'd1);
    push_en(c + 16, 2'd1);
    u_if.run_req = 1'b1; tick(1); u_if.run_req = 1'b0;
    check("run_state", u_if.state, 1);
    go_to(c + 17);
    u_if.stop_req = 1'b1; tick(1); u_if.stop_req = 1'b0;
    check("stop_state", u_if.state, 0);
    tick(8);
    check("run_step_cnt", u_if.step_cnt, 3);

    // Load clears step_cnt, then three single steps spaced 4 cycles.
    c = cyc;
    push_load(c + 1);
    u_if.load_req = 1'b1; tick(1); u_if.load_req = 1'b0;
    check("load_state", u_if.state, 3);
    check("load_step_cnt", u_if.step_cnt, 0);
    tick(1);
    check("post_load_state", u_if.state, 0);
    for (int k = 0; k < 3; k++) begin
      c = cyc;
      push_en(c + 1, 2'd2);
      u_if.step_req = 1'b1; tick(1); u_if.step_req = 1'b0;
      check("step_state", u_if.state, 2);
      tick(1);
      check("step_back_idle", u_if.state, 0);
      tick(2);
    end
    check("step_cnt_3", u_if.step_cnt, 3);

    // step_req during RUN is ignored; stop while counter is 1.
    c = cyc;
    push_en(c + 6, 2'd1);
    u_if.run_req = 1'b1; tick(1); u_if.run_req = 1'b0;
    go_to(c + 2);
    u_if.step_req = 1'b1; tick(1); u_if.step_req = 1'b0;
    go_to(c + 7);
    u_if.stop_req = 1'b1; tick(1); u_if.stop_req = 1'b0;
    tick(6);
    check("run_step_ignored_cnt", u_if.step_cnt, 4);

    // div_sel 0 -> 3 at counter=3, then -> 2; stop at a terminal count.
    u_if.div_sel = 2'd0;
    c = cyc;
    push_en(c + 5, 2'd1);
    push_en(c + 6, 2'd1);
    push_en(c + 7, 2'd1);
    push_en(c + 8, 2'd1);
    push_en(c + 10, 2'd1);
    push_en(c + 12, 2'd1);
    push_en(c + 14, 2'd1);
    u_if.run_req = 1'b1; tick(1); u_if.run_req = 1'b0;
    go_to(c + 4);
    u_if.div_sel = 2'd3;
    go_to(c + 8);
    u_if.div_sel = 2'd2;
    go_to(c + 15);
    u_if.stop_req = 1'b1; tick(1); u_if.stop_req = 1'b0;
    check("div_stop_state", u_if.state, 0);
    u_if.div_sel = 2'd0;
    tick(5);
    check("div_step_cnt", u_if.step_cnt, 11);

    // load+stop+step together in RUN: load wins.
    c = cyc;
    push_load(c + 4);
    u_if.run_req = 1'b1; tick(1); u_if.run_req = 1'b0;
    go_to(c + 3);
    u_if.load_req = 1'b1; u_if.stop_req = 1'b1; u_if.step_req = 1'b1;
    tick(1);
    u_if.load_req = 1'b0; u_if.stop_req = 1'b0; u_if.step_req = 1'b0;
    check("prio_state", u_if.state, 3);
    check("prio_load", u_if.lfsr_load, 1);
    check("prio_en", u_if.lfsr_en, 0);
    check("prio_step_cnt", u_if.step_cnt, 0);
    tick(1);
    check("prio_idle", u_if.state, 0);
    tick(3);

    // Reset mid-RUN with counter=2.
    c = cyc;
    push_en(c + 1, 2'd2);
    u_if.step_req = 1'b1; tick(1); u_if.step_req = 1'b0;
    tick(2);
    c = cyc;
    u_if.run_req = 1'b1; tick(1); u_if.run_req = 1'b0;
    go_to(c + 3);
    rst = 1'b1; tick(1);
    exp_cnt = 16'd0;
    check("rst_mid_state", u_if.state, 0);
    check("rst_mid_step_cnt", u_if.step_cnt, 0);
    check("rst_mid_en", u_if.lfsr_en, 0);
    rst = 1'b0;
    tick(8);

    // 65536 strobes at PER3=1: step_cnt passes 16'hFFFF and wraps to 0.
    u_if.div_sel = 2'd3;
    c = cyc;
    for (int k = 1; k <= 65536; k++) push_en(c + 1 + k, 2'd1);
    u_if.run_req = 1'b1; tick(1); u_if.run_req = 1'b0;
    go_to(c + 1 + 65536);
    u_if.stop_req = 1'b1; tick(1); u_if.stop_req = 1'b0;
    tick(4);
    check("wrap_step_cnt", u_if.step_cnt, 0);
    check("wrap_state", u_if.state, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
